// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encodings and FSM state type shared by the multicycle ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] c_OP_MUL = 3'd0;
    localparam logic [2:0] c_OP_ILL = 3'd1;
    localparam logic [2:0] c_OP_BEQ = 3'd2;
    localparam logic [2:0] c_OP_BLT = 3'd3;
    localparam logic [2:0] c_OP_ADD = 3'd4;
    localparam logic [2:0] c_OP_SUB = 3'd5;
    localparam logic [2:0] c_OP_AND = 3'd6;
    localparam logic [2:0] c_OP_OR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Brief    : Shift-add multiplier, one multiplier bit per step, low WIDTH bits.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic [WIDTH-1:0] o_product_next,
    output logic             o_finish
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next     = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product_next = w_acc_next;
    // The step in flight is the last one once no set multiplier bits remain above bit 0.
    assign o_finish       = (r_mplier[WIDTH-1:1] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Multicycle ALU with single-cycle EXEC ops and iterative MUL.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_BLT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ip_0,
    input  logic [WIDTH-1:0] ip_1,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] op_0,
    output logic             change_pc,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    alu_state_t       r_state;
    alu_state_t       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_opcode;
    logic [WIDTH-1:0] r_op_0;
    logic             r_change_pc;
    logic             r_zero;
    logic             r_illegal;

    logic             w_accept;
    logic             w_mul_load;
    logic             w_mul_step;
    logic             w_mul_finish;
    logic             w_retire;
    logic             w_lt;
    logic             w_branch;
    logic [WIDTH-1:0] w_mul_product;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mul_load   = 1'b0;
        w_mul_step   = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (opcode == c_OP_MUL) begin
                        w_mul_load   = 1'b1;
                        w_state_next = ST_MUL;
                    end else begin
                        w_state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                w_retire     = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_MUL: begin
                w_mul_step = 1'b1;
                if (w_mul_finish) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operands are frozen at accept so the caller may change inputs freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_opcode <= c_OP_ADD;
        end else if (w_accept) begin
            r_a      <= ip_0;
            r_b      <= ip_1;
            r_opcode <= opcode;
        end
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul_iter (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_mul_load),
        .i_step         (w_mul_step),
        .i_mcand        (ip_0),
        .i_mplier       (ip_1),
        .o_product_next (w_mul_product),
        .o_finish       (w_mul_finish)
    );

    assign w_diff = r_a - r_b;

    generate
        if (SIGNED_BLT) begin : g_blt_signed
            assign w_lt = ($signed(r_a) < $signed(r_b));
        end else begin : g_blt_unsigned
            assign w_lt = (r_a < r_b);
        end
    endgenerate

    always_comb begin
        w_result = '0;
        w_branch = 1'b0;
        case (r_opcode)
            c_OP_MUL: w_result = w_mul_product;
            c_OP_BEQ: begin
                w_result = w_diff;
                w_branch = (r_a == r_b);
            end
            c_OP_BLT: begin
                w_result = w_diff;
                w_branch = w_lt;
            end
            c_OP_ADD: w_result = r_a + r_b;
            c_OP_SUB: w_result = w_diff;
            c_OP_AND: w_result = r_a & r_b;
            c_OP_OR:  w_result = r_a | r_b;
            default:  w_result = '0;
        endcase
    end

    // Result flags update only on the edge entering DONE and hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_0      <= '0;
            r_change_pc <= 1'b0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
        end else if (w_retire) begin
            r_op_0      <= w_result;
            r_change_pc <= w_branch;
            r_zero      <= (w_result == '0);
            r_illegal   <= (r_opcode == c_OP_ILL);
        end
    end

    assign op_0      = r_op_0;
    assign change_pc = r_change_pc;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule : multicycle_alu
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Brief    : Randomized and directed self-checking bench for multicycle_alu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    localparam int W = 32;

    localparam logic [2:0] c_MUL = 3'd0;
    localparam logic [2:0] c_ILL = 3'd1;
    localparam logic [2:0] c_BEQ = 3'd2;
    localparam logic [2:0] c_BLT = 3'd3;
    localparam logic [2:0] c_ADD = 3'd4;
    localparam logic [2:0] c_SUB = 3'd5;
    localparam logic [2:0] c_AND = 3'd6;
    localparam logic [2:0] c_OR  = 3'd7;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         start  = 1'b0;
    logic [W-1:0] ip_0   = '0;
    logic [W-1:0] ip_1   = '0;
    logic [2:0]   opcode = 3'd0;

    logic [W-1:0] op_0_s, op_0_u;
    logic         cp_s, cp_u, zero_s, zero_u, busy_s, busy_u, done_s, done_u, ill_s, ill_u;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W), .SIGNED_BLT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .ip_0(ip_0), .ip_1(ip_1), .opcode(opcode),
        .op_0(op_0_s), .change_pc(cp_s), .zero(zero_s), .busy(busy_s), .done(done_s),
        .illegal(ill_s)
    );

    multicycle_alu #(.WIDTH(W), .SIGNED_BLT(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .ip_0(ip_0), .ip_1(ip_1), .opcode(opcode),
        .op_0(op_0_u), .change_pc(cp_u), .zero(zero_u), .busy(busy_u), .done(done_u),
        .illegal(ill_u)
    );

    always @(posedge clk) begin
        if (done_s) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what the operation means, plus how many cycles after the
    // accepting cycle done is expected (EXEC ops 2, MUL 1 + bits to consume).
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                  input bit sgn, output logic [W-1:0] res,
                                  output bit cp, output bit ill, output int lat);
        int steps;
        res = '0;
        cp  = 1'b0;
        ill = 1'b0;
        lat = 2;
        case (op)
            c_MUL: begin
                res   = a * b;
                steps = 1;
                for (int i = 0; i < W; i++) if (b[i]) steps = i + 1;
                lat   = steps + 1;
            end
            c_ILL: ill = 1'b1;
            c_BEQ: begin res = a - b; cp = (a == b); end
            c_BLT: begin
                res = a - b;
                cp  = sgn ? ($signed(a) < $signed(b)) : (a < b);
            end
            c_ADD: res = a + b;
            c_SUB: res = a - b;
            c_AND: res = a & b;
            default: res = a | b;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, b, input int poke_at);
        logic [W-1:0] er_s, er_u;
        bit           ecp_s, ecp_u, eill;
        int           lat, lat_u, cyc;
        model(op, a, b, 1'b1, er_s, ecp_s, eill, lat);
        model(op, a, b, 1'b0, er_u, ecp_u, eill, lat_u);
        cyc = 0;
        while (busy_s && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("idle_before_start", busy_s, 1'b0);
        start = 1'b1; opcode = op; ip_0 = a; ip_1 = b;
        @(posedge clk); #1;
        start = 1'b0; ip_0 = $urandom; ip_1 = $urandom; opcode = 3'($urandom);
        check("busy_after_accept", busy_s, 1'b1);
        cyc = 1;
        while (!done_s && cyc < W + 10) begin
            if (cyc == poke_at) begin
                start = 1'b1; opcode = c_AND; ip_0 = 5; ip_1 = 3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;
        check("latency", cyc, lat);
        check("op_0", op_0_s, er_s);
        check("change_pc", cp_s, ecp_s);
        check("zero", zero_s, (er_s == '0));
        check("illegal", ill_s, eill);
        check("done_u", done_u, 1'b1);
        check("op_0_u", op_0_u, er_u);
        check("change_pc_u", cp_u, ecp_u);
        @(posedge clk); #1;
        check("done_one_cycle", done_s, 1'b0);
        check("busy_after_done", busy_s, 1'b0);
        check("op_0_hold", op_0_s, er_s);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int sel;
        logic [W-1:0] a, b;
        logic [2:0] op;

        repeat (3) @(posedge clk);
        #1;
        check("rst_op_0", op_0_s, '0);
        check("rst_zero", zero_s, 1'b1);
        check("rst_change_pc", cp_s, 1'b0);
        check("rst_illegal", ill_s, 1'b0);
        check("rst_busy", busy_s, 1'b0);
        check("rst_done", done_s, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(c_ADD, 32'd15, 32'd10, 0);
        do_op(c_SUB, 32'd5, 32'd10, 0);
        do_op(c_BLT, 32'hFFFF_FFFB, 32'd1, 0);
        do_op(c_BEQ, 32'd10, 32'd10, 0);
        do_op(c_BEQ, 32'd10, 32'd11, 0);
        do_op(c_MUL, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op(c_MUL, 32'd7, 32'd3, 0);
        do_op(c_MUL, 32'd1234, 32'd0, 0);
        do_op(c_MUL, 32'd1234, 32'd1, 0);
        do_op(c_MUL, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4);
        do_op(c_ADD, 32'hFFFF_FFFF, 32'd1, 1);
        do_op(c_AND, 32'd5, 32'd3, 0);
        do_op(c_OR, 32'hF0F0_0000, 32'h0000_0F0F, 0);

        // A start presented during DONE must not be taken; the following IDLE cycle takes it.
        start = 1'b1; opcode = c_ADD; ip_0 = 2; ip_1 = 3;
        @(posedge clk); #1;
        opcode = c_SUB; ip_0 = 9; ip_1 = 4;
        base = 0;
        while (!done_s && base < 10) begin @(posedge clk); #1; base++; end
        check("done_seen", done_s, 1'b1);
        check("add_before_done_start", op_0_s, 32'd5);
        opcode = c_OR; ip_0 = 32'h30; ip_1 = 32'h0C;
        @(posedge clk); #1;
        check("start_in_done_ignored", busy_s, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_done_accepted", busy_s, 1'b1);
        base = 0;
        while (!done_s && base < 10) begin @(posedge clk); #1; base++; end
        check("op_after_done_start", op_0_s, 32'h3C);
        @(posedge clk); #1;

        // Leave illegal set, then abort a long MUL with reset.
        do_op(c_ILL, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        start = 1'b1; opcode = c_MUL; ip_0 = 32'hFFFF_FFFF; ip_1 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        base = n_done;
        rst = 1'b1; start = 1'b1; opcode = c_ADD; ip_0 = 7; ip_1 = 7;
        @(posedge clk); #1;
        check("midmul_rst_busy", busy_s, 1'b0);
        check("midmul_rst_done", done_s, 1'b0);
        check("midmul_rst_op_0", op_0_s, '0);
        check("midmul_rst_zero", zero_s, 1'b1);
        check("midmul_rst_change_pc", cp_s, 1'b0);
        check("midmul_rst_illegal", ill_s, 1'b0);
        @(posedge clk); #1;
        check("start_ignored_in_rst", busy_s, 1'b0);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("no_done_after_abort", n_done, base);
        do_op(c_ADD, 32'd1, 32'd1, 0);

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom);
            sel = $urandom_range(0, 3);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
                2: b = a;
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(op, a, b, $urandom_range(0, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multicycle_alu
`default_nettype wire
